// File: rtl/controle_ventoinha_niveis_pkg.sv
// Shared types and helpers for the multi-level fan controller.
package controle_ventoinha_pkg;

    typedef enum logic {
        ESTAVEL  = 1'b0,
        PENDENTE = 1'b1
    } estado_t;

    // Target duty for a level: integer floor of nivel*periodo/num_limites.
    function automatic int alvo_nivel(input int nivel, input int periodo, input int num_limites);
        return (nivel * periodo) / num_limites;
    endfunction

    // Unsigned subtract that clamps at zero (operands up to 32 bits).
    function automatic logic [31:0] sub_sat(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/controle_ventoinha_niveis_gerador_pwm.sv
// Fan PWM generator: free-running period counter with a registered compare output.
module gerador_pwm #(
    parameter int PWM_PERIODO = 100
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [$clog2(PWM_PERIODO+1)-1:0] duty,
    output logic                             pwm
);

    localparam int CW = (PWM_PERIODO > 1) ? $clog2(PWM_PERIODO) : 1;

    logic [CW-1:0] contador;

    always_ff @(posedge clock) begin
        if (!reset) begin
            contador <= '0;
            pwm      <= 1'b0;
        end else begin
            pwm      <= (int'(contador) < int'(duty));
            contador <= (contador == CW'(PWM_PERIODO - 1)) ? '0 : contador + 1'b1;
        end
    end

endmodule

// File: rtl/controle_ventoinha_niveis.sv
// Multi-level fan control: hysteretic level quantiser with confirmation, duty ramp, PWM.
// Optional full-duty spin-up kick when built with `define KICKSTART_EN.
module controle_ventoinha_niveis
    import controle_ventoinha_pkg::*;
#(
    parameter int W           = 16,
    parameter int NUM_LIMITES = 4,
    parameter int CONFIRMA    = 2,
    parameter int PWM_PERIODO = 100,
    parameter int RAMPA_TICKS = 4,
    parameter int RAMPA_PASSO = 5
`ifdef KICKSTART_EN
    ,
    parameter int KICK_CICLOS = 50
`endif
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             amostra_valida,
    input  logic [W-1:0]                     temperatura,
    input  logic [NUM_LIMITES*W-1:0]         limites,
    input  logic [W-1:0]                     histerese,
    output logic [$clog2(NUM_LIMITES+1)-1:0] nivel,
    output logic [$clog2(PWM_PERIODO+1)-1:0] duty,
    output logic                             pwm_ventoinha,
    output logic                             mudou_nivel,
    output logic                             ocupado
);

    localparam int NW = $clog2(NUM_LIMITES + 1);
    localparam int DW = $clog2(PWM_PERIODO + 1);
    localparam int CW = $clog2(CONFIRMA + 1);
    localparam int TW = (RAMPA_TICKS > 1) ? $clog2(RAMPA_TICKS) : 1;

    logic [NW-1:0] n_sobe;
    logic [NW-1:0] n_desce;
    logic [NW-1:0] candidato;
    logic [NW-1:0] pendente;
    logic [CW-1:0] contagem;
    estado_t       estado;
    logic [DW-1:0] alvo;
    logic [DW-1:0] tabela_alvo [NUM_LIMITES+1];
    logic [TW-1:0] tick;
    logic          passo_rampa;

    // One ramp step from atual toward destino, clamped so it never overshoots.
    function automatic logic [DW-1:0] passo_duty(input logic [DW-1:0] atual,
                                                 input logic [DW-1:0] destino);
        if (atual < destino) begin
            return (int'(destino) - int'(atual) > RAMPA_PASSO) ? DW'(int'(atual) + RAMPA_PASSO) : destino;
        end else if (atual > destino) begin
            return (int'(atual) - int'(destino) > RAMPA_PASSO) ? DW'(int'(atual) - RAMPA_PASSO) : destino;
        end
        return atual;
    endfunction

    always_comb begin : contagem_limiares
        n_sobe  = '0;
        n_desce = '0;
        for (int i = 0; i < NUM_LIMITES; i++) begin
            if (temperatura >= limites[i*W +: W]) begin
                n_sobe = n_sobe + NW'(1);
            end
            if (temperatura >= W'(sub_sat(32'(limites[i*W +: W]), 32'(histerese)))) begin
                n_desce = n_desce + NW'(1);
            end
        end
    end

    // Rising uses the raw limits, falling uses limits lowered by the hysteresis band.
    always_comb begin
        candidato = nivel;
        if (n_sobe > nivel) begin
            candidato = n_sobe;
        end else if (n_desce < nivel) begin
            candidato = n_desce;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= ESTAVEL;
            pendente    <= '0;
            contagem    <= '0;
            nivel       <= '0;
            mudou_nivel <= 1'b0;
        end else begin
            mudou_nivel <= 1'b0;
            if (amostra_valida) begin
                if (candidato == nivel) begin
                    estado   <= ESTAVEL;
                    contagem <= '0;
                end else if (estado == ESTAVEL || candidato != pendente) begin
                    if (CONFIRMA == 1) begin
                        nivel       <= candidato;
                        mudou_nivel <= 1'b1;
                        estado      <= ESTAVEL;
                        contagem    <= '0;
                    end else begin
                        pendente <= candidato;
                        contagem <= CW'(1);
                        estado   <= PENDENTE;
                    end
                end else if (int'(contagem) + 1 >= CONFIRMA) begin
                    nivel       <= pendente;
                    mudou_nivel <= 1'b1;
                    estado      <= ESTAVEL;
                    contagem    <= '0;
                end else begin
                    contagem <= contagem + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g <= NUM_LIMITES; g++) begin : g_tabela
        assign tabela_alvo[g] = DW'(alvo_nivel(g, PWM_PERIODO, NUM_LIMITES));
    end

    assign alvo = tabela_alvo[nivel];

    always_ff @(posedge clock) begin
        if (!reset) begin
            tick <= '0;
        end else begin
            tick <= (tick == TW'(RAMPA_TICKS - 1)) ? '0 : tick + 1'b1;
        end
    end

    assign passo_rampa = (tick == TW'(RAMPA_TICKS - 1));

`ifdef KICKSTART_EN
    localparam int KW = (KICK_CICLOS > 1) ? $clog2(KICK_CICLOS) : 1;

    logic          kick_ativo;
    logic [KW-1:0] kick_cont;

    // Spinning up from standstill: hold full duty, then jump straight to the target.
    always_ff @(posedge clock) begin
        if (!reset) begin
            duty       <= '0;
            kick_ativo <= 1'b0;
            kick_cont  <= '0;
        end else if (kick_ativo) begin
            if (alvo == '0) begin
                duty       <= '0;
                kick_ativo <= 1'b0;
            end else if (kick_cont == '0) begin
                duty       <= alvo;
                kick_ativo <= 1'b0;
            end else begin
                kick_cont <= kick_cont - 1'b1;
            end
        end else if (duty == '0 && alvo != '0) begin
            duty       <= DW'(PWM_PERIODO);
            kick_ativo <= 1'b1;
            kick_cont  <= KW'(KICK_CICLOS - 1);
        end else if (passo_rampa) begin
            duty <= passo_duty(duty, alvo);
        end
    end

    assign ocupado = (duty != alvo) || kick_ativo;
`else
    always_ff @(posedge clock) begin
        if (!reset) begin
            duty <= '0;
        end else if (passo_rampa) begin
            duty <= passo_duty(duty, alvo);
        end
    end

    assign ocupado = (duty != alvo);
`endif

    gerador_pwm #(
        .PWM_PERIODO(PWM_PERIODO)
    ) u_gerador_pwm (
        .clock(clock),
        .reset(reset),
        .duty (duty),
        .pwm  (pwm_ventoinha)
    );

endmodule
